time_date_counter: RTL

Parametrised successor to the alarm-clock time/date calculator. Free-running real-time clock/calendar driven by a CLK-rate prescaler. Supports 12/24-hour display, month-length and leap-year aware date roll-over, validated time/date loads and a freeze for setting. Sits between the key/setting FSM, which loads values, and the display formatter, which reads OUT_TIME/OUT_DATE.

---
 rtl/time_date_counter_if.sv | 31 +++
 rtl/time_date_counter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/time_date_counter_if.sv
// Bus between the key/setting FSM (master) and the time/date counter (slave).
// The counter drives the OUT_*, pulse and alarm-readback signals; the master drives the rest.
interface time_date_counter_if;
  logic        HOLD;
  logic        MODE_12H;
  logic        LOAD_TIME;
  logic [17:0] IN_TIME;
  logic        LOAD_DATE;
  logic [15:0] IN_DATE;
  logic [17:0] OUT_TIME;
  logic [15:0] OUT_DATE;
  logic        SEC_TICK;
  logic        LOAD_ERR;
  logic        ALARM_SET;
  logic [16:0] IN_ALARM_TIME;
  logic        ALARM_ON;
  logic [16:0] OUT_ALARM_TIME;
  logic        ALARM_MATCH;

  modport master (
    output HOLD, MODE_12H, LOAD_TIME, IN_TIME, LOAD_DATE, IN_DATE,
           ALARM_SET, IN_ALARM_TIME, ALARM_ON,
    input  OUT_TIME, OUT_DATE, SEC_TICK, LOAD_ERR, OUT_ALARM_TIME, ALARM_MATCH
  );

  modport slave (
    input  HOLD, MODE_12H, LOAD_TIME, IN_TIME, LOAD_DATE, IN_DATE,
           ALARM_SET, IN_ALARM_TIME, ALARM_ON,
    output OUT_TIME, OUT_DATE, SEC_TICK, LOAD_ERR, OUT_ALARM_TIME, ALARM_MATCH
  );
endinterface

// File: rtl/time_date_counter.sv
// Real-time clock/calendar with CLK-rate prescaler, 12/24-hour formatting,
// leap-year aware date roll-over and validated loads.
// Optional alarm compare is enabled by defining TIME_DATE_ALARM_EN.
module time_date_counter #(
  parameter int TICKS_PER_SEC = 100,
  parameter int YEAR_MAX      = 99
) (
  input logic CLK,
  input logic RESET,
  time_date_counter_if.slave bus
);
  localparam int CNT_W = $clog2(TICKS_PER_SEC);
  localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_SEC - 1);
  localparam logic [6:0]       YMAX = 7'(YEAR_MAX);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0] hr_q, hr_d;
  logic [5:0] mn_q, mn_d, sc_q, sc_d;
  logic [6:0] yr_q, yr_d;
  logic [3:0] mo_q, mo_d;
  logic [4:0] dy_q, dy_d;
  logic       tick, day_carry, time_ok, date_ok, time_ld, alarm_err;
  logic [4:0] in_hr, ld_hr, disp_hr;
  logic       disp_mer;

  // Year offsets are based at 2000, so year 100 (2100) is not a leap year.
  function automatic logic [4:0] month_len(input logic [3:0] m, input logic [6:0] y);
    case (m)
      4'd2:                      return (y[1:0] == 2'b00 && y != 7'd100) ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  // Validate load requests and convert a 12-hour load into the internal 0-23 hour.
  always_comb begin
    in_hr = bus.IN_TIME[16:12];
    ld_hr = in_hr;
    if (bus.MODE_12H) begin
      time_ok = (in_hr >= 5'd1) && (in_hr <= 5'd12);
      if (in_hr == 5'd12) ld_hr = bus.IN_TIME[17] ? 5'd12 : 5'd0;
      else                ld_hr = bus.IN_TIME[17] ? in_hr + 5'd12 : in_hr;
    end else begin
      time_ok = in_hr <= 5'd23;
    end
    time_ok = time_ok && (bus.IN_TIME[11:6] <= 6'd59) && (bus.IN_TIME[5:0] <= 6'd59);
    date_ok = (bus.IN_DATE[8:5] >= 4'd1) && (bus.IN_DATE[8:5] <= 4'd12) &&
              (bus.IN_DATE[4:0] != 5'd0) &&
              (bus.IN_DATE[4:0] <= month_len(bus.IN_DATE[8:5], bus.IN_DATE[15:9])) &&
              (bus.IN_DATE[15:9] <= YMAX);
    time_ld = bus.LOAD_TIME && time_ok;
  end

  // Prescaler, seconds tick and time/date carries. A valid time load swallows
  // a coincident tick; a valid date load wins over a midnight date carry.
  always_comb begin
    cnt_d = cnt_q;
    hr_d = hr_q; mn_d = mn_q; sc_d = sc_q;
    yr_d = yr_q; mo_d = mo_q; dy_d = dy_q;
    day_carry = 1'b0;
    tick = !bus.HOLD && (cnt_q == TERM) && !time_ld;
    if (bus.HOLD || time_ld || cnt_q == TERM) cnt_d = '0;
    else                                      cnt_d = cnt_q + 1'b1;

    if (time_ld) begin
      hr_d = ld_hr;
      mn_d = bus.IN_TIME[11:6];
      sc_d = bus.IN_TIME[5:0];
    end else if (tick) begin
      if (sc_q == 6'd59) begin
        sc_d = 6'd0;
        if (mn_q == 6'd59) begin
          mn_d = 6'd0;
          if (hr_q == 5'd23) begin
            hr_d = 5'd0;
            day_carry = 1'b1;
          end else begin
            hr_d = hr_q + 5'd1;
          end
        end else begin
          mn_d = mn_q + 6'd1;
        end
      end else begin
        sc_d = sc_q + 6'd1;
      end
    end

    if (bus.LOAD_DATE && date_ok) begin
      {yr_d, mo_d, dy_d} = bus.IN_DATE;
    end else if (day_carry) begin
      if (dy_q >= month_len(mo_q, yr_q)) begin
        dy_d = 5'd1;
        if (mo_q == 4'd12) begin
          mo_d = 4'd1;
          yr_d = (yr_q == YMAX) ? 7'd0 : yr_q + 7'd1;
        end else begin
          mo_d = mo_q + 4'd1;
        end
      end else begin
        dy_d = dy_q + 5'd1;
      end
    end
  end

  // Display formatting; MODE_12H only affects this view, never the state.
  always_comb begin
    disp_mer = 1'b0;
    disp_hr  = hr_q;
    if (bus.MODE_12H) begin
      disp_mer = hr_q >= 5'd12;
      if (hr_q == 5'd0)       disp_hr = 5'd12;
      else if (hr_q > 5'd12)  disp_hr = hr_q - 5'd12;
    end
  end

  // State and registered outputs.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q <= '0;
      hr_q <= 5'd0; mn_q <= 6'd0; sc_q <= 6'd0;
      yr_q <= 7'd0; mo_q <= 4'd1; dy_q <= 5'd1;
      bus.OUT_TIME <= 18'd0;
      bus.OUT_DATE <= {7'd0, 4'd1, 5'd1};
      bus.SEC_TICK <= 1'b0;
      bus.LOAD_ERR <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      hr_q <= hr_d; mn_q <= mn_d; sc_q <= sc_d;
      yr_q <= yr_d; mo_q <= mo_d; dy_q <= dy_d;
      bus.OUT_TIME <= {disp_mer, disp_hr, mn_q, sc_q};
      bus.OUT_DATE <= {yr_q, mo_q, dy_q};
      bus.SEC_TICK <= tick;
      bus.LOAD_ERR <= (bus.LOAD_TIME && !time_ok) || (bus.LOAD_DATE && !date_ok) || alarm_err;
    end
  end

`ifdef TIME_DATE_ALARM_EN
  logic [16:0] alarm_q;
  logic        alarm_ok;

  assign alarm_ok  = (bus.IN_ALARM_TIME[16:12] <= 5'd23) &&
                     (bus.IN_ALARM_TIME[11:6] <= 6'd59) && (bus.IN_ALARM_TIME[5:0] <= 6'd59);
  assign alarm_err = bus.ALARM_SET && !alarm_ok;
  assign bus.OUT_ALARM_TIME = alarm_q;

  // Alarm store and match; only tick-driven advances can hit, never a load.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      alarm_q         <= 17'd0;
      bus.ALARM_MATCH <= 1'b0;
    end else begin
      if (bus.ALARM_SET && alarm_ok) alarm_q <= bus.IN_ALARM_TIME;
      bus.ALARM_MATCH <= tick && bus.ALARM_ON && ({hr_d, mn_d, sc_d} == alarm_q);
    end
  end
`else
  logic unused_alarm;
  assign unused_alarm       = ^{bus.ALARM_SET, bus.IN_ALARM_TIME, bus.ALARM_ON};
  assign alarm_err          = 1'b0;
  assign bus.OUT_ALARM_TIME = 17'd0;
  assign bus.ALARM_MATCH    = 1'b0;
`endif
endmodule
